// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory-wait stall with timeout, branch-redirect flush,
// load-use bubble, and saturating event counters.
module hazard_control_unit #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs1_decode,
  input  logic [4:0]       rs2_decode,
  input  logic             uses_rs1_decode,
  input  logic             uses_rs2_decode,
  input  logic [4:0]       rd_execute,
  input  logic             memRead_execute,
  input  logic [1:0]       next_PC_select_execute,
  input  logic             memRead_memory,
  input  logic             memWrite_memory,
  input  logic             mem_ready,
  output logic             stall,
  output logic             hold_front,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] load_use_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       load_use, redirect, mem_wait;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    stall         = 1'b0;
    hold_front    = 1'b0;
    bubble_idex   = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;

    load_use = memRead_execute && (rd_execute != 5'd0) &&
               ((uses_rs1_decode && (rs1_decode == rd_execute)) ||
                (uses_rs2_decode && (rs2_decode == rd_execute)));
    redirect = (next_PC_select_execute != 2'b00);
    mem_wait = (memRead_memory || memWrite_memory) && !mem_ready;

    case (state)
      RUN: begin
        if (mem_wait) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else begin
          wait_cnt_next = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt < MAX_WAIT_C) begin
          wait_cnt_next = wait_cnt + 8'd1;
        end else begin
          state_next = TIMEOUT;
        end
      end
      TIMEOUT: state_next = TIMEOUT;
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase

    // While reset is asserted the stale state must not leak into the freeze signal.
    stall       = mem_wait || ((state == TIMEOUT) && !reset);
    flush_ifid  = redirect && !stall;
    flush_idex  = redirect && !stall;
    hold_front  = load_use && !redirect && !stall;
    bubble_idex = load_use && !redirect && !stall;
  end

  assign mem_timeout = (state == TIMEOUT);

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count    <= '0;
      load_use_count <= '0;
      flush_count    <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_ONE;
      if (hold_front && (load_use_count != '1))
        load_use_count <= load_use_count + CNT_ONE;
      if (flush_idex && (flush_count != '1))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum memory-wait cycles before timeout, range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 clock  input  1  rising-edge clock; reset is synchronous, active-high, named reset.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rs1_decode, rs2_decode  input  5 each  source registers of the instruction in ID.
REQ-006 uses_rs1_decode, uses_rs2_decode  input  1 each  ID instruction reads rs1/rs2.
REQ-007 rd_execute  input  5  destination register of the instruction in EX; memRead_execute  input  1  EX instruction is a load.
REQ-008 next_PC_select_execute  input  2  non-zero means the EX instruction redirects the PC.
REQ-009 memRead_memory, memWrite_memory  input  1 each  MEM-stage access request; mem_ready  input  1  data memory completes the access this cycle.
REQ-010 stall  output  1  global freeze of PC, IF/ID, ID/EX and EX/MEM.
REQ-011 hold_front  output  1  freeze of PC and IF/ID only (load-use).
REQ-012 bubble_idex  output  1  load an all-zero NOP into ID/EX.
REQ-013 flush_ifid, flush_idex  output  1 each  squash IF/ID and ID/EX contents.
REQ-014 mem_timeout  output  1  sticky memory-timeout error.
REQ-015 stall_count, load_use_count, flush_count  output  CNT_W each  saturating event counters.

Function
REQ-016 load_use = memRead_execute && rd_execute!=0 && ((uses_rs1_decode && rs1_decode==rd_execute) || (uses_rs2_decode && rs2_decode==rd_execute)).
REQ-017 redirect = (next_PC_select_execute != 2'b00); mem_wait = (memRead_memory || memWrite_memory) && !mem_ready.
REQ-018 FSM states: RUN, MEM_WAIT, TIMEOUT; a 8-bit wait counter wait_cnt.
REQ-019 RUN -> MEM_WAIT when mem_wait, with wait_cnt <= 1; otherwise stay in RUN with wait_cnt <= 0.
REQ-020 MEM_WAIT -> RUN when !mem_wait, with wait_cnt <= 0; MEM_WAIT stays and increments wait_cnt while mem_wait and wait_cnt < MAX_WAIT.
REQ-021 MEM_WAIT -> TIMEOUT when mem_wait and wait_cnt == MAX_WAIT; TIMEOUT is left only by reset.
REQ-022 stall = mem_wait || (state == TIMEOUT), combinational, same cycle.
REQ-023 mem_timeout = (state == TIMEOUT), registered state decode.
REQ-024 flush_ifid = flush_idex = redirect && !stall.
REQ-025 hold_front = bubble_idex = load_use && !redirect && !stall.
REQ-026 Priority is stall > redirect > load_use; at most one of {stall, flush_*, hold_front} is asserted in any cycle.
REQ-027 A redirect held during stall produces its flush in the first cycle stall is 0; no flush is lost or duplicated.
REQ-028 The load-use bubble lasts exactly one cycle per load-use pair, because the load advances to MEM on the next edge.
REQ-029 stall_count increments each cycle stall==1.
REQ-030 load_use_count increments each cycle hold_front==1.
REQ-031 flush_count increments each cycle flush_idex==1.
REQ-032 All counters saturate at 2^CNT_W-1 and never wrap.
REQ-033 Inputs with rd_execute==0 never cause hold_front, whatever the register match.

Reset
REQ-034 reset takes priority over all other inputs.
REQ-035 On reset: state=RUN, wait_cnt=0, mem_timeout=0, all counters=0.
REQ-036 On the reset cycle and the cycle after it, the combinational outputs depend only on the current inputs.
REQ-037 Reset asserted during MEM_WAIT or TIMEOUT returns the FSM to RUN on the next edge.

Verification
REQ-038 memRead_execute=1, rd_execute=5, rs1_decode=5, uses_rs1_decode=1, redirect=0, no MEM request -> hold_front=bubble_idex=1 for one cycle, load_use_count=1.
REQ-039 Same load-use with rd_execute=0 -> hold_front=0 and load_use_count unchanged.
REQ-040 Load-use and next_PC_select_execute=2'b01 in the same cycle -> flush_ifid=flush_idex=1, hold_front=0, flush_count=1.
REQ-041 memRead_memory=1 with mem_ready=0 for 3 cycles, then mem_ready=1 -> stall=1 for exactly 3 cycles, stall_count=3, FSM back in RUN, mem_timeout=0.
REQ-042 Redirect present while mem_ready=0 for 2 cycles -> flush_* stay 0 during the stall, then flush_* =1 for one cycle after release.
REQ-043 mem_ready held 0 with MAX_WAIT=15 -> TIMEOUT entered after the 16th wait cycle, stall and mem_timeout stay 1 until reset, and all outputs clear after reset.
